regfile_wb_sb: RTL and testbench

Parametrised register file for the pipelined CPU that folds write-back source selection into the block. Sources are ALU result, LBI immediate, and link value PC+PC_INC. Adds same-cycle write-through bypass and a per-register busy scoreboard for RAW/WAW hazard stalls at issue. Sits between decode (read/issue side) and write-back (write side).

---
 rtl/rf_pkg.sv | 20 ++
 rtl/regfile_wb_sb_if.sv | 52 +++++
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/regfile_wb_sb.sv | 90 +++++++++
 tb/tb_regfile_wb_sb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared types and default sizing for the write-back register file slice.
// Holds the write-back source encoding used by both the top and the bench.
// -----------------------------------------------------------------------------
package rf_pkg;

   // Write-back source select; WB_RSVD writes the ALU value and flags an error
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_IMM  = 2'd1,
      WB_LINK = 2'd2,
      WB_RSVD = 2'd3
   } wb_src_t;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_PC_INC   = 2;

endpackage

// File: rtl/regfile_wb_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_sb_if
// Bundles the decode-side read/issue signals and the write-back bus of the
// register file.
//   master : decode + write-back stage (drives selects, issue and wb fields)
//   slave  : register file (returns read data, stall and err)
// Read data and stall are combinational; err is registered.
// -----------------------------------------------------------------------------
interface regfile_wb_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);

   // read ports
   logic [ADDR_W-1:0] rd1_sel;
   logic [ADDR_W-1:0] rd2_sel;
   logic [DATA_W-1:0] rd1_data;
   logic [DATA_W-1:0] rd2_data;

   // issue side
   logic              iss_valid;
   logic              iss_use1;
   logic              iss_use2;
   logic              iss_wr;
   logic              iss_link;
   logic [ADDR_W-1:0] iss_dst;
   logic              stall;

   // write-back side
   logic              wb_valid;
   logic [1:0]        wb_src;
   logic [ADDR_W-1:0] wb_dst;
   logic [DATA_W-1:0] wb_alu;
   logic [DATA_W-1:0] wb_imm;
   logic [DATA_W-1:0] wb_pc;
   logic              err;

   modport master (
      output rd1_sel, rd2_sel,
      output iss_valid, iss_use1, iss_use2, iss_wr, iss_link, iss_dst,
      output wb_valid, wb_src, wb_dst, wb_alu, wb_imm, wb_pc,
      input  rd1_data, rd2_data, stall, err
   );

   modport slave (
      input  rd1_sel, rd2_sel,
      input  iss_valid, iss_use1, iss_use2, iss_wr, iss_link, iss_dst,
      input  wb_valid, wb_src, wb_dst, wb_alu, wb_imm, wb_pc,
      output rd1_data, rd2_data, stall, err
   );

endinterface

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy tracking for RAW/WAW issue hazards.
//   clk, rst          : clock, synchronous active-high reset
//   iss_valid/use1/use2/wr, idst : issue request, idst already link-resolved
//   rd1_sel, rd2_sel  : source indices of the issuing instruction
//   wb_valid, wdst    : write-back strobe, wdst already link-resolved
//   wb_rsvd           : write-back used the reserved source encoding
//   stall             : combinational issue block
//   err               : registered one-cycle pulse on an unclaimed or
//                       reserved-source write-back
// -----------------------------------------------------------------------------
module rf_scoreboard #(
   parameter  int NUM_REGS = 8,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_valid,
   input  logic              iss_use1,
   input  logic              iss_use2,
   input  logic              iss_wr,
   input  logic [ADDR_W-1:0] idst,
   input  logic [ADDR_W-1:0] rd1_sel,
   input  logic [ADDR_W-1:0] rd2_sel,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wdst,
   input  logic              wb_rsvd,
   output logic              stall,
   output logic              err
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] busy_eff;
   logic                err_nxt;

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (wb_valid)
         clr_mask = NUM_REGS'(1) << wdst;
      // A write-back this cycle releases its register for this cycle's
      // hazard check, so a retry can issue alongside the producing write.
      busy_eff = busy & ~clr_mask;
      stall    = iss_valid & ((iss_use1 & busy_eff[rd1_sel]) |
                              (iss_use2 & busy_eff[rd2_sel]) |
                              (iss_wr   & busy_eff[idst]));
      if (iss_valid && iss_wr && !stall)
         set_mask = NUM_REGS'(1) << idst;
      // Old busy is used here: a claim issued this cycle does not cover
      // a write-back that lands in the same cycle.
      err_nxt  = wb_valid & (~busy[wdst] | wb_rsvd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         // set applied after clear so a new claim survives a same-cycle release
         busy <= busy_eff | set_mask;
         err  <= err_nxt;
      end
   end

endmodule

// File: rtl/regfile_wb_sb.sv
// -----------------------------------------------------------------------------
// regfile_wb_sb
// Register file with write-back source selection, same-cycle write-through
// bypass and a busy scoreboard for issue stalls.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (registers, busy bits, err -> 0)
//   bus  : regfile_wb_sb_if.slave
//          rd1/rd2 sel->data (combinational, bypassed from write-back)
//          iss_* request -> stall (combinational)
//          wb_* write-back (commits at the edge) -> err (registered pulse)
// -----------------------------------------------------------------------------
module regfile_wb_sb
   import rf_pkg::*;
#(
   parameter  int DATA_W   = DEF_DATA_W,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   parameter  int LINK_REG = NUM_REGS - 1,
   parameter  int PC_INC   = DEF_PC_INC,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic           clk,
   input  logic           rst,
   regfile_wb_sb_if.slave bus
);

   localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] link_data;
   logic [ADDR_W-1:0] wdst;
   logic [ADDR_W-1:0] idst;
   logic              wb_rsvd;
   wb_src_t           src;

   always_comb begin
      src       = wb_src_t'(bus.wb_src);
      wb_rsvd   = (src == WB_RSVD);
      // adder wraps at DATA_W, so a PC at the top of memory links low
      link_data = bus.wb_pc + DATA_W'(PC_INC);
      wdst      = (src == WB_LINK) ? LINK_IDX : bus.wb_dst;
      idst      = bus.iss_link ? LINK_IDX : bus.iss_dst;
      case (src)
         WB_ALU:  wdata = bus.wb_alu;
         WB_IMM:  wdata = bus.wb_imm;
         WB_LINK: wdata = link_data;
         WB_RSVD: wdata = bus.wb_alu;
         default: wdata = bus.wb_alu;
      endcase
   end

   // write-through bypass: a reader sees the value landing this cycle
   always_comb begin
      bus.rd1_data = regs[bus.rd1_sel];
      bus.rd2_data = regs[bus.rd2_sel];
      if (bus.wb_valid && (bus.rd1_sel == wdst))
         bus.rd1_data = wdata;
      if (bus.wb_valid && (bus.rd2_sel == wdst))
         bus.rd2_data = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (bus.wb_valid) begin
         regs[wdst] <= wdata;
      end
   end

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (bus.iss_valid),
      .iss_use1  (bus.iss_use1),
      .iss_use2  (bus.iss_use2),
      .iss_wr    (bus.iss_wr),
      .idst      (idst),
      .rd1_sel   (bus.rd1_sel),
      .rd2_sel   (bus.rd2_sel),
      .wb_valid  (bus.wb_valid),
      .wdst      (wdst),
      .wb_rsvd   (wb_rsvd),
      .stall     (bus.stall),
      .err       (bus.err)
   );

endmodule

// File: tb/tb_regfile_wb_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sb
// Directed scenarios followed by randomized traffic, compared against a
// register-file/busy-set reference model kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sb;

   localparam int DW = 16;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam int LR = NR - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wb_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_wb_sb #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .LINK_REG (LR),
      .PC_INC   (2)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // reference model state
   logic [DW-1:0] m_regs [NR];
   bit            m_busy [NR];
   bit            m_err;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.iss_valid = 0; bus.iss_use1 = 0; bus.iss_use2 = 0;
      bus.iss_wr = 0; bus.iss_link = 0; bus.iss_dst = 0;
      bus.wb_valid = 0; bus.wb_src = 0; bus.wb_dst = 0;
      bus.wb_alu = 0; bus.wb_imm = 0; bus.wb_pc = 0;
   endtask

   // Check combinational outputs against the model, clock once, advance the
   // model, then check the registered err.
   task automatic tick();
      int            wd_idx, id_idx;
      logic [DW-1:0] wd;
      bit            bz [NR];
      bit            st, e;
      #1;
      wd_idx = (bus.wb_src == 2) ? LR : int'(bus.wb_dst);
      id_idx = bus.iss_link ? LR : int'(bus.iss_dst);
      case (bus.wb_src)
         2'd1:    wd = bus.wb_imm;
         2'd2:    wd = DW'((int'(bus.wb_pc) + 2) % 65536);
         default: wd = bus.wb_alu;
      endcase
      for (int i = 0; i < NR; i++) bz[i] = m_busy[i];
      if (bus.wb_valid) bz[wd_idx] = 0;
      st = bus.iss_valid && ((bus.iss_use1 && bz[bus.rd1_sel]) ||
                             (bus.iss_use2 && bz[bus.rd2_sel]) ||
                             (bus.iss_wr   && bz[id_idx]));
      chk("stall", bus.stall, st);
      chk("rd1", bus.rd1_data,
          (bus.wb_valid && int'(bus.rd1_sel) == wd_idx) ? wd : m_regs[bus.rd1_sel]);
      chk("rd2", bus.rd2_data,
          (bus.wb_valid && int'(bus.rd2_sel) == wd_idx) ? wd : m_regs[bus.rd2_sel]);
      e = bus.wb_valid && (!m_busy[wd_idx] || bus.wb_src == 3);
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
         m_err = 0;
      end else begin
         if (bus.wb_valid) m_regs[wd_idx] = wd;
         for (int i = 0; i < NR; i++) m_busy[i] = bz[i];
         if (bus.iss_valid && bus.iss_wr && !st) m_busy[id_idx] = 1;
         m_err = e;
      end
      #1;
      chk("err", bus.err, m_err);
   endtask

   initial begin
      int pick;
      idle();
      bus.rd1_sel = 0; bus.rd2_sel = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_err = 0;

      // reset state
      chk("rst_err", bus.err, 0);
      chk("rst_stall", bus.stall, 0);
      for (int i = 0; i < NR; i++) begin
         bus.rd1_sel = AW'(i); bus.rd2_sel = AW'(NR - 1 - i);
         #1;
         chk("rst_rd1", bus.rd1_data, 0);
         chk("rst_rd2", bus.rd2_data, 0);
      end

      // claim r3, then ALU write 0x1234
      idle(); bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 3; tick();
      idle(); bus.wb_valid = 1; bus.wb_src = 0; bus.wb_dst = 3; bus.wb_alu = 16'h1234; tick();
      chk("alu_err", bus.err, 0);
      idle(); bus.rd1_sel = 3; #1;
      chk("alu_r3", bus.rd1_data, 16'h1234);

      // link write wraps and ignores wb_dst
      idle(); bus.wb_valid = 1; bus.wb_src = 2; bus.wb_dst = 2; bus.wb_pc = 16'hFFFF; tick();
      chk("link_err", bus.err, 1);
      idle(); bus.rd1_sel = 7; bus.rd2_sel = 2; #1;
      chk("link_r7", bus.rd1_data, 16'h0001);
      chk("link_r2", bus.rd2_data, 16'h0000);

      // same-cycle bypass
      idle(); bus.wb_valid = 1; bus.wb_src = 1; bus.wb_dst = 5; bus.wb_imm = 16'h00AB;
      bus.rd1_sel = 5; #1;
      chk("bypass_r5", bus.rd1_data, 16'h00AB);
      tick();

      // RAW: claim r4, retry stalls, retry with wb releases
      idle(); bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 4; tick();
      idle(); bus.iss_valid = 1; bus.iss_use1 = 1; bus.rd1_sel = 4; #1;
      chk("raw_stall", bus.stall, 1);
      tick();
      bus.wb_valid = 1; bus.wb_src = 0; bus.wb_dst = 4; bus.wb_alu = 16'h4444; #1;
      chk("raw_release", bus.stall, 0);
      tick();

      // WAW with simultaneous clear and set of r6
      idle(); bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 6; tick();
      idle(); bus.wb_valid = 1; bus.wb_dst = 6; bus.wb_alu = 16'h0606;
      bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 6; #1;
      chk("waw_stall", bus.stall, 0);
      tick();
      idle(); bus.iss_valid = 1; bus.iss_use1 = 1; bus.rd1_sel = 6; #1;
      chk("waw_busy", bus.stall, 1);
      tick();

      // unclaimed write to r1: err for exactly one cycle
      idle(); bus.wb_valid = 1; bus.wb_dst = 1; bus.wb_alu = 16'h5555; tick();
      chk("unclaimed_err", bus.err, 1);
      idle(); bus.rd1_sel = 1; tick();
      chk("unclaimed_err_drop", bus.err, 0);
      chk("unclaimed_r1", bus.rd1_data, 16'h5555);

      // reserved source on a claimed register still writes wb_alu and errs
      idle(); bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 0; tick();
      idle(); bus.wb_valid = 1; bus.wb_src = 3; bus.wb_dst = 0;
      bus.wb_alu = 16'hBEEF; bus.wb_imm = 16'h1111; tick();
      chk("rsvd_err", bus.err, 1);
      idle(); bus.rd2_sel = 0; #1;
      chk("rsvd_r0", bus.rd2_data, 16'hBEEF);

      // reset discards claims; later write-back flags err
      idle(); bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_dst = 2; tick();
      rst = 1; idle(); bus.wb_valid = 1; bus.wb_dst = 5; bus.wb_alu = 16'h7777; tick();
      rst = 0; idle(); bus.rd1_sel = 5; #1;
      chk("rst_ovr_r5", bus.rd1_data, 0);
      bus.wb_valid = 1; bus.wb_dst = 2; bus.wb_alu = 16'h2222; tick();
      chk("rst_ovr_err", bus.err, 1);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         rst           = ($urandom_range(0, 99) == 0);
         bus.rd1_sel   = AW'($urandom_range(0, NR - 1));
         bus.rd2_sel   = AW'($urandom_range(0, NR - 1));
         bus.iss_valid = $urandom_range(0, 1);
         bus.iss_use1  = $urandom_range(0, 1);
         bus.iss_use2  = $urandom_range(0, 1);
         bus.iss_wr    = $urandom_range(0, 1);
         bus.iss_link  = ($urandom_range(0, 7) == 0);
         bus.iss_dst   = AW'($urandom_range(0, NR - 1));
         bus.wb_valid  = $urandom_range(0, 1);
         bus.wb_src    = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         bus.wb_dst    = AW'($urandom_range(0, NR - 1));
         // bias write-backs toward claimed registers
         if ($urandom_range(0, 3) != 0) begin
            pick = $urandom_range(0, NR - 1);
            for (int k = 0; k < NR; k++)
               if (m_busy[(pick + k) % NR]) begin
                  bus.wb_dst = AW'((pick + k) % NR);
                  break;
               end
         end
         bus.wb_alu = DW'($urandom);
         bus.wb_imm = DW'($urandom);
         bus.wb_pc  = ($urandom_range(0, 15) == 0) ? 16'hFFFF : DW'($urandom);
         tick();
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
